// File: rtl/clint_ctrl_pkg.sv
// rtl/clint_ctrl_pkg.sv - widths, CSR addresses, mcause codes, mstatus fields and FSM states for clint_ctrl
package clint_ctrl_pkg;

   localparam int RV32_ADDR_WIDTH = 32;
   localparam int RV32_DATA_WIDTH = 32;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [RV32_DATA_WIDTH-1:0] MCAUSE_ECALL_M   = 32'h0000_000B;
   localparam logic [RV32_DATA_WIDTH-1:0] MCAUSE_EBREAK    = 32'h0000_0003;
   localparam logic [RV32_DATA_WIDTH-1:0] MCAUSE_IRQ_EXT_M = 32'h8000_000B;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP  = 11;

   // Direct mode only: the mode bits of mtvec never reach the PC.
   localparam logic [RV32_ADDR_WIDTH-1:0] MTVEC_BASE_MASK = 32'hFFFF_FFFC;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_S_MEPC    = 3'd1,
      ST_S_MCAUSE  = 3'd2,
      ST_S_MSTATUS = 3'd3,
      ST_S_JUMP    = 3'd4,
      ST_R_MSTATUS = 3'd5,
      ST_R_JUMP    = 3'd6
   } clint_state_e;

   function automatic logic [RV32_ADDR_WIDTH-1:0] csr_addr(input logic [11:0] a);
      return {{(RV32_ADDR_WIDTH-12){1'b0}}, a};
   endfunction

   function automatic logic [RV32_DATA_WIDTH-1:0] mstatus_on_trap(input logic [RV32_DATA_WIDTH-1:0] s);
      logic [RV32_DATA_WIDTH-1:0] r;
      r                   = s;
      r[MSTATUS_MPIE]     = s[MSTATUS_MIE];
      r[MSTATUS_MIE]      = 1'b0;
      r[MSTATUS_MPP +: 2] = 2'b11;
      return r;
   endfunction

   function automatic logic [RV32_DATA_WIDTH-1:0] mstatus_on_mret(input logic [RV32_DATA_WIDTH-1:0] s);
      logic [RV32_DATA_WIDTH-1:0] r;
      r                   = s;
      r[MSTATUS_MIE]      = s[MSTATUS_MPIE];
      r[MSTATUS_MPIE]     = 1'b1;
      r[MSTATUS_MPP +: 2] = 2'b11;
      return r;
   endfunction

endpackage

// File: rtl/clint_ctrl_if.sv
// rtl/clint_ctrl_if.sv - pipeline/CSR-file side signals of the trap sequencer
interface clint_ctrl_if;
   import clint_ctrl_pkg::*;

   logic                       i_ex_valid;
   logic [RV32_ADDR_WIDTH-1:0] i_ex_pc;
   logic                       i_ecall;
   logic                       i_ebreak;
   logic                       i_mret;
   logic                       i_irq_ext;
   logic [RV32_DATA_WIDTH-1:0] i_csr_mstatus;
   logic [RV32_DATA_WIDTH-1:0] i_csr_mepc;
   logic [RV32_DATA_WIDTH-1:0] i_csr_mtvec;

   logic                       o_clint_mode;
   logic                       o_clint_csr_wr_en;
   logic [RV32_ADDR_WIDTH-1:0] o_clint_csr_wr_addr;
   logic [RV32_DATA_WIDTH-1:0] o_clint_csr_wr_data;
   logic                       o_stall;
   logic                       o_flush;
   logic                       o_jump_en;
   logic [RV32_ADDR_WIDTH-1:0] o_jump_addr;

   modport master (
      output i_ex_valid, i_ex_pc, i_ecall, i_ebreak, i_mret, i_irq_ext,
      output i_csr_mstatus, i_csr_mepc, i_csr_mtvec,
      input  o_clint_mode, o_clint_csr_wr_en, o_clint_csr_wr_addr, o_clint_csr_wr_data,
      input  o_stall, o_flush, o_jump_en, o_jump_addr
   );

   modport slave (
      input  i_ex_valid, i_ex_pc, i_ecall, i_ebreak, i_mret, i_irq_ext,
      input  i_csr_mstatus, i_csr_mepc, i_csr_mtvec,
      output o_clint_mode, o_clint_csr_wr_en, o_clint_csr_wr_addr, o_clint_csr_wr_data,
      output o_stall, o_flush, o_jump_en, o_jump_addr
   );

endinterface

// File: rtl/clint_ctrl.sv
// rtl/clint_ctrl.sv - trap entry/return sequencer driving the CSR write port, stall, flush and redirect
module clint_ctrl
   import clint_ctrl_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   clint_ctrl_if.slave bus
);

   clint_state_e               state_q, state_d;
   logic [RV32_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [RV32_DATA_WIDTH-1:0] cause_q, cause_d;
   logic                       req_ecall, req_ebreak, req_mret, req_irq, req_trap;

   // Fixed priority ecall > ebreak > mret > interrupt, all qualified by a live EX instruction.
   always_comb begin
      req_ecall  = bus.i_ex_valid & bus.i_ecall;
      req_ebreak = bus.i_ex_valid & bus.i_ebreak & ~bus.i_ecall;
      req_mret   = bus.i_ex_valid & bus.i_mret & ~bus.i_ecall & ~bus.i_ebreak;
      req_irq    = bus.i_ex_valid & bus.i_irq_ext & bus.i_csr_mstatus[MSTATUS_MIE]
                   & ~bus.i_ecall & ~bus.i_ebreak & ~bus.i_mret;
      req_trap   = req_ecall | req_ebreak | req_irq;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d                 = state_q;
      pc_d                    = pc_q;
      cause_d                 = cause_q;
      bus.o_clint_mode        = 1'b1;
      bus.o_clint_csr_wr_en   = 1'b0;
      bus.o_clint_csr_wr_addr = '0;
      bus.o_clint_csr_wr_data = '0;
      bus.o_stall             = 1'b1;
      bus.o_flush             = 1'b0;
      bus.o_jump_en           = 1'b0;
      bus.o_jump_addr         = '0;

      case (state_q)
         ST_IDLE: begin
            bus.o_clint_mode = 1'b0;
            bus.o_stall      = req_trap | req_mret;
            if (req_trap | req_mret) begin
               pc_d = bus.i_ex_pc;
            end
            if (req_ecall) begin
               cause_d = MCAUSE_ECALL_M;
            end else if (req_ebreak) begin
               cause_d = MCAUSE_EBREAK;
            end else if (req_irq) begin
               cause_d = MCAUSE_IRQ_EXT_M;
            end
            if (req_trap) begin
               state_d = ST_S_MEPC;
            end else if (req_mret) begin
               state_d = ST_R_MSTATUS;
            end
         end
         ST_S_MEPC: begin
            bus.o_clint_csr_wr_en   = 1'b1;
            bus.o_clint_csr_wr_addr = csr_addr(CSR_MEPC);
            bus.o_clint_csr_wr_data = pc_q;
            state_d                 = ST_S_MCAUSE;
         end
         ST_S_MCAUSE: begin
            bus.o_clint_csr_wr_en   = 1'b1;
            bus.o_clint_csr_wr_addr = csr_addr(CSR_MCAUSE);
            bus.o_clint_csr_wr_data = cause_q;
            state_d                 = ST_S_MSTATUS;
         end
         ST_S_MSTATUS: begin
            bus.o_clint_csr_wr_en   = 1'b1;
            bus.o_clint_csr_wr_addr = csr_addr(CSR_MSTATUS);
            bus.o_clint_csr_wr_data = mstatus_on_trap(bus.i_csr_mstatus);
            state_d                 = ST_S_JUMP;
         end
         ST_S_JUMP: begin
            bus.o_flush     = 1'b1;
            bus.o_jump_en   = 1'b1;
            bus.o_jump_addr = bus.i_csr_mtvec & MTVEC_BASE_MASK;
            state_d         = ST_IDLE;
         end
         ST_R_MSTATUS: begin
            bus.o_clint_csr_wr_en   = 1'b1;
            bus.o_clint_csr_wr_addr = csr_addr(CSR_MSTATUS);
            bus.o_clint_csr_wr_data = mstatus_on_mret(bus.i_csr_mstatus);
            state_d                 = ST_R_JUMP;
         end
         ST_R_JUMP: begin
            bus.o_flush     = 1'b1;
            bus.o_jump_en   = 1'b1;
            bus.o_jump_addr = bus.i_csr_mepc;
            state_d         = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are silenced for the whole reset cycle, including the combinational stall.
      if (!rst_n) begin
         bus.o_clint_mode        = 1'b0;
         bus.o_clint_csr_wr_en   = 1'b0;
         bus.o_clint_csr_wr_addr = '0;
         bus.o_clint_csr_wr_data = '0;
         bus.o_stall             = 1'b0;
         bus.o_flush             = 1'b0;
         bus.o_jump_en           = 1'b0;
         bus.o_jump_addr         = '0;
      end
   end

endmodule

// File: tb/tb_clint_ctrl.sv
// tb/tb_clint_ctrl.sv - directed self-checking bench for clint_ctrl with a minimal CSR-file model
module tb_clint_ctrl;

   typedef struct packed {
      logic        mode;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic        stall;
      logic        flush;
      logic        jen;
      logic [31:0] jaddr;
   } obs_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] mcause_r;
   int          n_tests;
   int          n_fail;

   clint_ctrl_if bus();

   clint_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      return '{bus.o_clint_mode, bus.o_clint_csr_wr_en, bus.o_clint_csr_wr_addr,
               bus.o_clint_csr_wr_data, bus.o_stall, bus.o_flush, bus.o_jump_en, bus.o_jump_addr};
   endfunction

   function automatic obs_t zero();
      return '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0};
   endfunction

   function automatic obs_t idle_stall();
      return '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
   endfunction

   function automatic obs_t wr(input logic [31:0] a, input logic [31:0] d);
      return '{1'b1, 1'b1, a, d, 1'b1, 1'b0, 1'b0, 32'h0};
   endfunction

   function automatic obs_t jmp(input logic [31:0] t);
      return '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, t};
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic e,
                        input logic b, input logic m, input logic q);
      bus.i_ex_valid = v;
      bus.i_ex_pc    = pc;
      bus.i_ecall    = e;
      bus.i_ebreak   = b;
      bus.i_mret     = m;
      bus.i_irq_ext  = q;
   endtask

   // Advance one clock; the CSR file registers whatever the DUT was writing before the edge.
   task automatic step();
      obs_t o;
      o = sample();
      @(posedge clk);
      #1;
      if (o.we) begin
         case (o.addr)
            32'h341: bus.i_csr_mepc    = o.data;
            32'h342: mcause_r          = o.data;
            32'h300: bus.i_csr_mstatus = o.data;
            default: ;
         endcase
      end
   endtask

   task automatic test_reset();
      obs_t got;
      rst_n = 1'b0;
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      bus.i_csr_mstatus = 32'h8;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            rst_n = 1'b1;
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
         #1;
         got = sample();
         n_tests++;
         if (got !== zero()) begin
            n_fail++;
            $display("FAIL reset cycle %0d: got %h expected %h", i, got, zero());
         end
         step();
      end
   endtask

   task automatic test_ecall();
      obs_t got;
      obs_t exp_v [6];
      bus.i_csr_mstatus = 32'h8;
      bus.i_csr_mtvec   = 32'h200;
      drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = '{idle_stall(), wr(32'h341, 32'h100), wr(32'h342, 32'hB),
                wr(32'h300, 32'h1880), jmp(32'h200), zero()};
      for (int i = 0; i < 6; i++) begin
         if (i == 1) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         got = sample();
         n_tests++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL ecall cycle %0d: got %h expected %h", i, got, exp_v[i]);
         end
         step();
      end
      n_tests++;
      if (bus.i_csr_mepc !== 32'h100 || mcause_r !== 32'hB || bus.i_csr_mstatus !== 32'h1880) begin
         n_fail++;
         $display("FAIL ecall csrs: got mepc=%h mcause=%h mstatus=%h expected 100 b 1880",
                  bus.i_csr_mepc, mcause_r, bus.i_csr_mstatus);
      end
   endtask

   task automatic test_ebreak();
      obs_t got;
      obs_t exp_v [6];
      bus.i_csr_mstatus = 32'h1880;
      bus.i_csr_mtvec   = 32'h203;
      drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_v = '{idle_stall(), wr(32'h341, 32'h44), wr(32'h342, 32'h3),
                wr(32'h300, 32'h1800), jmp(32'h200), zero()};
      for (int i = 0; i < 6; i++) begin
         if (i == 1) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         got = sample();
         n_tests++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL ebreak cycle %0d: got %h expected %h", i, got, exp_v[i]);
         end
         step();
      end
   endtask

   task automatic test_irq();
      obs_t got;
      obs_t exp_v [10];
      bus.i_csr_mstatus = 32'h0;
      bus.i_csr_mtvec   = 32'h200;
      drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_v = '{zero(), zero(), zero(), idle_stall(), wr(32'h341, 32'h300),
                wr(32'h342, 32'h8000_000B), wr(32'h300, 32'h1880), jmp(32'h200), zero(), zero()};
      for (int i = 0; i < 10; i++) begin
         if (i == 3) bus.i_csr_mstatus = 32'h8;
         #1;
         got = sample();
         n_tests++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL irq cycle %0d: got %h expected %h", i, got, exp_v[i]);
         end
         step();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (bus.i_csr_mepc !== 32'h300 || mcause_r !== 32'h8000_000B) begin
         n_fail++;
         $display("FAIL irq csrs: got mepc=%h mcause=%h expected 300 8000000b", bus.i_csr_mepc, mcause_r);
      end
   endtask

   task automatic test_mret();
      obs_t got;
      obs_t exp_v [4];
      bus.i_csr_mepc    = 32'h104;
      bus.i_csr_mstatus = 32'h1880;
      drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_v = '{idle_stall(), wr(32'h300, 32'h1888), jmp(32'h104), zero()};
      for (int i = 0; i < 4; i++) begin
         if (i == 1) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         got = sample();
         n_tests++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL mret cycle %0d: got %h expected %h", i, got, exp_v[i]);
         end
         step();
      end
   endtask

   task automatic test_ecall_irq_priority();
      obs_t got;
      obs_t exp_v [15];
      bus.i_csr_mstatus = 32'h8;
      bus.i_csr_mtvec   = 32'h200;
      drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1);
      exp_v = '{idle_stall(), wr(32'h341, 32'h500), wr(32'h342, 32'hB), wr(32'h300, 32'h1880),
                jmp(32'h200), zero(),
                idle_stall(), wr(32'h300, 32'h1888), jmp(32'h500),
                idle_stall(), wr(32'h341, 32'h500), wr(32'h342, 32'h8000_000B),
                wr(32'h300, 32'h1880), jmp(32'h200), zero()};
      for (int i = 0; i < 15; i++) begin
         case (i)
            1:       drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1);
            6:       drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1);
            7:       drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1);
            9:       drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
            10:      drive(1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0);
            default: ;
         endcase
         #1;
         got = sample();
         n_tests++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL prio cycle %0d: got %h expected %h", i, got, exp_v[i]);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_trap();
      obs_t got;
      obs_t exp_v [5];
      bus.i_csr_mstatus = 32'h8;
      bus.i_csr_mtvec   = 32'h200;
      mcause_r          = 32'h0;
      drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_v = '{idle_stall(), wr(32'h341, 32'h600), zero(), zero(), zero()};
      for (int i = 0; i < 5; i++) begin
         if (i == 1) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 2) rst_n = 1'b0;
         if (i == 3) rst_n = 1'b1;
         #1;
         got = sample();
         n_tests++;
         if (got !== exp_v[i]) begin
            n_fail++;
            $display("FAIL rstmid cycle %0d: got %h expected %h", i, got, exp_v[i]);
         end
         step();
      end
      n_tests++;
      if (bus.i_csr_mstatus !== 32'h8 || mcause_r !== 32'h0 || bus.i_csr_mepc !== 32'h600) begin
         n_fail++;
         $display("FAIL rstmid csrs: got mstatus=%h mcause=%h mepc=%h expected 8 0 600",
                  bus.i_csr_mstatus, mcause_r, bus.i_csr_mepc);
      end
   endtask

   initial begin
      n_tests           = 0;
      n_fail            = 0;
      rst_n             = 1'b0;
      mcause_r          = 32'h0;
      bus.i_csr_mstatus = 32'h0;
      bus.i_csr_mepc    = 32'h0;
      bus.i_csr_mtvec   = 32'h0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_ecall();
      test_ebreak();
      test_irq();
      test_mret();
      test_ecall_irq_priority();
      test_reset_mid_trap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
